sq_ring: RTL and testbench
==========================

# sq_ring

Store-queue ring buffer for the LSQ. It holds up to N in-flight stores in program order: entries are allocated at dispatch, filled with address and data at execute, and drained in order at retire. It also exports a per-entry address-match mask plus the head index. These feed the circular barrel shifter (`in_data` = `match_mask`, `nshifts` = `head`), which rotates the match mask into age order for load-forwarding selection.

## Interface
- `N`, default `SQ_SIZE` (8): number of entries; must be a power of 2 and at least 2.
- `AW`, default 32: address width.
- `DW`, default 32: store data width.
- `clock` in 1: single clock, all state updates on the rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `flush` in 1: squash every entry.
- `disp_valid` in 1: allocate one entry at the tail.
- `disp_ready` out 1: queue not full.
- `disp_idx` out $clog2(N): index that a dispatch this cycle receives (equals `tail`).
- `ex_valid` in 1: execute fill.
- `ex_idx` in $clog2(N): entry to fill.
- `ex_addr` in AW: store address.
- `ex_data` in DW: store data.
- `rt_valid` in 1: retire (pop) the head entry.
- `rt_ready` out 1: head entry is valid and filled.
- `rt_addr` out AW: head entry address.
- `rt_data` out DW: head entry data.
- `ld_addr` in AW: load address to compare.
- `valid_mask` out N: bit i is set when entry i is allocated.
- `match_mask` out N: bit i is set when entry i is valid, filled, and `addr[i] == ld_addr`.
- `head` out $clog2(N): oldest entry index.
- `count` out $clog2(N)+1: number of valid entries.

## Operation
- **State:** `head`, `tail`, `count`, plus per-entry `valid`, `filled`, `addr`, `data`.
- **Pointers:** `head` and `tail` are $clog2(N) bits and wrap modulo N naturally (N-1 + 1 gives 0).
  - Empty when `count == 0`; full when `count == N`. `head == tail` alone never decides full or empty.
- **Dispatch:** accepted when `disp_valid && disp_ready`.
  - Sets `valid[tail] = 1` and `filled[tail] = 0`.
  - Then `tail <= tail + 1`.
- **Execute:** accepted when `ex_valid && valid[ex_idx]`.
  - Writes `addr` and `data` and sets `filled = 1`.
  - An execute to an invalid entry is ignored, including an entry being dispatched in the same cycle.
  - Re-executing a filled entry overwrites it.
- **Retire:** accepted when `rt_valid && rt_ready`.
  - Clears `valid[head]` and `filled[head]`.
  - Then `head <= head + 1`.
  - `rt_valid` while `rt_ready == 0` is ignored.
- **Count update:** `count` changes by (dispatch accepted) − (retire accepted). Simultaneous dispatch and retire leave `count` unchanged.
- **Flush:** has priority over dispatch, execute and retire in the same cycle.
  - Next cycle: all `valid` and `filled` are 0, and `head = tail = count = 0`.
- **Combinational outputs** (derived from registered state):
  - `disp_ready = (count != N)`. There is no bypass: when full, a same-cycle retire does not enable dispatch.
  - `rt_ready = valid[head] && filled[head]`.
  - `rt_addr` and `rt_data` = the head entry's fields, regardless of `rt_ready`.
- **Match mask:** purely combinational in `ld_addr`. No ordering is applied here; age ordering is the downstream shifter's job.

## Timing
- Dispatch, execute, retire and flush all take effect at the next rising edge.
  - `valid_mask`, `count`, pointers and `rt_ready` reflect them in the following cycle.
- **Retire after fill:** an entry filled in cycle t can retire at the earliest in cycle t+1 (`rt_ready` is high in t+1).
- **Match mask latency:** zero cycles from `ld_addr` to `match_mask`, and one cycle from an execute fill.
- **Reset** (`reset_n` low, asynchronous, effective immediately):
  - `head = 0`, `tail = 0`, `count = 0`, `disp_idx = 0`.
  - `disp_ready = 1`, `rt_ready = 0`.
  - `valid_mask = 0`, `match_mask = 0`.
  - `addr` and `data` are cleared to 0, so `rt_addr = 0` and `rt_data = 0`.
- **Mid-operation reset:** asserting reset while the queue is partially full discards all entries. No retire output is produced.
- **Deassertion:** synchronized externally. The first dispatch is accepted on the first edge after release.

## Test plan
- **Reset:** assert `reset_n = 0` mid-run with `count = 5` → `count = 0`, `disp_ready = 1`, `rt_ready = 0`, masks `0x00` immediately, without waiting for a clock.
- **Fill to full:** N=8, dispatch 8 consecutive cycles → `disp_idx` runs 0..7, `count = 8`, `disp_ready = 0`, `valid_mask = 0xFF`. A 9th `disp_valid` leaves state unchanged. Dispatch plus retire while full → only the retire is taken, `count = 7`.
- **In-order retire:** fill entries 0..2 with addresses 0x100, 0x104, 0x108 out of order (2, 0, 1). Assert `rt_valid` continuously → `rt_addr` sequence is 0x100, 0x104, 0x108, and each entry retires only once it is filled.
- **Wrap-around:** dispatch 8, retire 6, then dispatch 3 → `tail = 3`, `head = 6`, `count = 5`, `valid_mask = 0xC7`. The subsequent retires pop entries 6, 7, 0, 1, 2.
- **Match mask:**
  - Setup: with `head = 6`, entries 7 and 1 filled with 0x200 and entry 0 filled with 0x204; `ld_addr = 0x200` → `match_mask = 0x82`.
  - Change to `ld_addr = 0x204` → `match_mask = 0x01` in the same cycle.
  - Execute to invalid entry 4 → ignored, `match_mask` unaffected.
- **Flush:** flush together with dispatch, execute and retire at `count = 4` → next cycle `count = 0`, `head = tail = 0`, `valid_mask = 0`, and no retire is accepted.

Source files
------------

// File: rtl/sq_ring.sv
// sq_ring: in-order store-queue ring buffer with per-entry load-address match mask.
// Entries are allocated at the tail, filled by execute, and retired from the head.
module sq_ring #(
    parameter int N  = 8,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    output logic [$clog2(N)-1:0] disp_idx,
    input  logic                 ex_valid,
    input  logic [$clog2(N)-1:0] ex_idx,
    input  logic [AW-1:0]        ex_addr,
    input  logic [DW-1:0]        ex_data,
    input  logic                 rt_valid,
    output logic                 rt_ready,
    output logic [AW-1:0]        rt_addr,
    output logic [DW-1:0]        rt_data,
    input  logic [AW-1:0]        ld_addr,
    output logic [N-1:0]         valid_mask,
    output logic [N-1:0]         match_mask,
    output logic [$clog2(N)-1:0] head,
    output logic [$clog2(N):0]   count
);
    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    logic [N-1:0]  valid_q, valid_d, filled_q, filled_d;
    logic [AW-1:0] addr_q [N];
    logic [AW-1:0] addr_d [N];
    logic [DW-1:0] data_q [N];
    logic [DW-1:0] data_d [N];
    logic [IW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          disp_go, ex_go, rt_go;

    assign disp_ready = count_q != CW'(N);
    assign disp_idx   = tail_q;
    assign rt_ready   = valid_q[head_q] && filled_q[head_q];
    assign rt_addr    = addr_q[head_q];
    assign rt_data    = data_q[head_q];
    assign valid_mask = valid_q;
    assign head       = head_q;
    assign count      = count_q;
    assign disp_go    = disp_valid && disp_ready;
    assign ex_go      = ex_valid && valid_q[ex_idx];
    assign rt_go      = rt_valid && rt_ready;

    always_comb begin
        match_mask = '0;
        for (int i = 0; i < N; i++)
            match_mask[i] = valid_q[i] && filled_q[i] && (addr_q[i] == ld_addr);
    end

    // Execute is applied before retire so a fill racing a retire of the same entry is discarded.
    always_comb begin
        valid_d  = valid_q;
        filled_d = filled_q;
        addr_d   = addr_q;
        data_d   = data_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush) begin
            valid_d  = '0;
            filled_d = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end else begin
            if (ex_go) begin
                addr_d[ex_idx]   = ex_addr;
                data_d[ex_idx]   = ex_data;
                filled_d[ex_idx] = 1'b1;
            end
            if (disp_go) begin
                valid_d[tail_q]  = 1'b1;
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + 1'b1;
            end
            if (rt_go) begin
                valid_d[head_q]  = 1'b0;
                filled_d[head_q] = 1'b0;
                head_d           = head_q + 1'b1;
            end
            count_d = count_q + CW'(disp_go) - CW'(rt_go);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            filled_q <= '0;
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            filled_q <= filled_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_sq_ring.sv
// tb_sq_ring: random and directed stimulus for sq_ring, checked every cycle against
// a queue model that tracks head and occupancy and derives the tail from them.
module tb_sq_ring;
    logic        clock = 0;
    logic        reset_n = 1;
    logic        flush = 0, disp_valid = 0, ex_valid = 0, rt_valid = 0;
    logic [2:0]  ex_idx = 0;
    logic [31:0] ex_addr = 0, ex_data = 0, ld_addr = 0;
    logic        disp_ready, rt_ready;
    logic [2:0]  disp_idx, head;
    logic [3:0]  count;
    logic [31:0] rt_addr, rt_data;
    logic [7:0]  valid_mask, match_mask;

    sq_ring #(.N(8), .AW(32), .DW(32)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_idx(disp_idx),
        .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_addr(ex_addr), .ex_data(ex_data),
        .rt_valid(rt_valid), .rt_ready(rt_ready), .rt_addr(rt_addr), .rt_data(rt_data),
        .ld_addr(ld_addr), .valid_mask(valid_mask), .match_mask(match_mask),
        .head(head), .count(count)
    );

    always #5 clock = ~clock;

    int n_pass = 0, n_total = 0;
    bit          m_valid [8];
    bit          m_filled [8];
    logic [31:0] m_addr [8];
    logic [31:0] m_data [8];
    int          m_head, m_count;
    logic [31:0] pop_addr [$];
    int          pop_idx [$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_filled[i] = 0; m_addr[i] = 0; m_data[i] = 0;
        end
        m_head = 0; m_count = 0;
    endtask

    task automatic check();
        logic [7:0] vm, mm;
        for (int i = 0; i < 8; i++) begin
            vm[i] = m_valid[i];
            mm[i] = m_valid[i] && m_filled[i] && m_addr[i] == ld_addr;
        end
        chk("count", count, m_count);
        chk("head", head, m_head);
        chk("disp_idx", disp_idx, (m_head + m_count) % 8);
        chk("disp_ready", disp_ready, m_count != 8);
        chk("rt_ready", rt_ready, m_valid[m_head] && m_filled[m_head]);
        chk("rt_addr", rt_addr, m_addr[m_head]);
        chk("rt_data", rt_data, m_data[m_head]);
        chk("valid_mask", valid_mask, vm);
        chk("match_mask", match_mask, mm);
    endtask

    // Called at a falling edge with inputs set; checks, advances the model, then waits one cycle.
    task automatic step();
        int  t;
        bit  dg, eg, rg;
        #1;
        check();
        if (rt_valid && rt_ready) begin
            pop_addr.push_back(rt_addr);
            pop_idx.push_back(int'(head));
        end
        if (flush) begin
            for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_filled[i] = 0; end
            m_head = 0; m_count = 0;
        end else begin
            t  = (m_head + m_count) % 8;
            dg = disp_valid && m_count != 8;
            eg = ex_valid && m_valid[ex_idx];
            rg = rt_valid && m_valid[m_head] && m_filled[m_head];
            if (eg) begin m_addr[ex_idx] = ex_addr; m_data[ex_idx] = ex_data; m_filled[ex_idx] = 1; end
            if (dg) begin m_valid[t] = 1; m_filled[t] = 0; end
            if (rg) begin m_valid[m_head] = 0; m_filled[m_head] = 0; m_head = (m_head + 1) % 8; end
            m_count = m_count + int'(dg) - int'(rg);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; ex_valid = 0; rt_valid = 0; ex_data = $urandom;
    endtask

    task automatic ex(int idx, logic [31:0] a);
        idle(); ex_valid = 1; ex_idx = 3'(idx); ex_addr = a; step();
    endtask

    task automatic disp(int n);
        for (int i = 0; i < n; i++) begin idle(); disp_valid = 1; step(); end
    endtask

    initial begin
        logic [31:0] exp_addr [3];
        int          exp_idx [5];
        exp_addr = '{32'h100, 32'h104, 32'h108};
        exp_idx  = '{6, 7, 0, 1, 2};
        m_reset();
        #2 reset_n = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_ready", disp_ready, 1);
        chk("rst_rt_ready", rt_ready, 0);
        @(negedge clock) reset_n = 1;

        // fill to full
        for (int i = 0; i < 8; i++) begin
            idle(); disp_valid = 1; #1 chk("fill_disp_idx", disp_idx, i); step();
        end
        #1;
        chk("full_count", count, 8);
        chk("full_ready", disp_ready, 0);
        chk("full_vm", valid_mask, 8'hFF);
        idle(); disp_valid = 1; step();
        #1 chk("ninth_count", count, 8);
        ex(0, 32'h10);
        idle(); disp_valid = 1; rt_valid = 1; step();
        #1 chk("full_dr_count", count, 7);
        idle(); flush = 1; step();

        // in-order retire with out-of-order fills
        disp(3);
        pop_addr.delete();
        idle(); rt_valid = 1; ex_valid = 1;
        ex_idx = 2; ex_addr = 32'h108; step();
        ex_idx = 0; ex_addr = 32'h100; step();
        ex_idx = 1; ex_addr = 32'h104; step();
        ex_valid = 0; step(); step(); step();
        chk("pop_n", pop_addr.size(), 3);
        for (int i = 0; i < 3 && i < pop_addr.size(); i++) chk("pop_addr", pop_addr[i], exp_addr[i]);

        // wrap-around
        idle(); flush = 1; step();
        disp(8);
        for (int i = 0; i < 8; i++) ex(i, 32'h300 + 32'(4 * i));
        for (int i = 0; i < 6; i++) begin idle(); rt_valid = 1; step(); end
        disp(3);
        #1;
        chk("wrap_tail", disp_idx, 3);
        chk("wrap_head", head, 6);
        chk("wrap_count", count, 5);
        chk("wrap_vm", valid_mask, 8'hC7);

        // match mask
        ex(7, 32'h200); ex(1, 32'h200); ex(0, 32'h204);
        idle(); ld_addr = 32'h200; #1 chk("mm_200", match_mask, 8'h82);
        ld_addr = 32'h204; #1 chk("mm_204", match_mask, 8'h01);
        ex(4, 32'h204);
        #1 chk("mm_inval", match_mask, 8'h01);
        ex(2, 32'h208);
        pop_idx.delete();
        for (int i = 0; i < 5; i++) begin idle(); rt_valid = 1; step(); end
        chk("wrap_pop_n", pop_idx.size(), 5);
        for (int i = 0; i < 5 && i < pop_idx.size(); i++) chk("wrap_pop_idx", pop_idx[i], exp_idx[i]);

        // flush beats dispatch/execute/retire
        disp(4);
        ex(3, 32'h400);
        idle(); flush = 1; disp_valid = 1; rt_valid = 1; ex_valid = 1; ex_idx = 4; step();
        idle();
        #1;
        chk("fl_count", count, 0);
        chk("fl_head", head, 0);
        chk("fl_tail", disp_idx, 0);
        chk("fl_vm", valid_mask, 0);

        // asynchronous mid-run reset
        disp(5);
        ex(0, 32'h500);
        #1 chk("pre_rst_count", count, 5);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready", disp_ready, 1);
        chk("mid_rst_rt_ready", rt_ready, 0);
        chk("mid_rst_vm", valid_mask, 0);
        chk("mid_rst_mm", match_mask, 0);
        chk("mid_rst_rt_addr", rt_addr, 0);
        m_reset();
        @(negedge clock) reset_n = 1;
        disp(1);
        #1 chk("post_rst_count", count, 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            flush      = ($urandom % 40) == 0;
            disp_valid = ($urandom % 3) != 0;
            ex_valid   = $urandom % 2;
            ex_idx     = 3'($urandom % 8);
            ex_addr    = 32'h200 + 32'(4 * ($urandom % 4));
            ex_data    = $urandom;
            rt_valid   = $urandom % 2;
            ld_addr    = 32'h200 + 32'(4 * ($urandom % 4));
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
